// File: rtl/sram_controller.sv
// sram_controller: sequences single 32-bit load/store requests onto a
// 64-bit-data, 17-bit-address asynchronous SRAM. It stalls the pipeline through
// `ready` for a fixed access time, and it drives or releases the shared data bus.
// The optional one-entry read line buffer is enabled by defining SRAM_LINE_BUF_EN.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [16:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    inout  wire  [63:0] SRAM_DQ
);

    // Access counter runs 0..WAIT_CYCLES-1 while in BUSY.
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("sram_controller: WAIT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic               is_write_q, is_write_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [16:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               we_n_q, we_n_d;
    logic               dq_oe_q, dq_oe_d;

    logic [16:0]        word_addr;
    logic [31:0]        dq_half;
    logic               last_cycle;
    logic               lb_hit;

    // Byte address relative to the SRAM window, in 32-bit words, truncated.
    assign word_addr  = 17'((address - 32'(BASE_ADDR)) >> 2);
    // Word address bit 0 picks which half of the 64-bit SRAM word is returned.
    assign dq_half    = addr_q[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
    assign last_cycle = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

`ifdef SRAM_LINE_BUF_EN
    logic               lb_valid_q, lb_valid_d;
    logic [15:0]        lb_tag_q, lb_tag_d;
    logic [63:0]        lb_data_q, lb_data_d;
    logic [31:0]        lb_half;

    // A hit only counts for a pure read seen while idle. A store takes priority over a load.
    assign lb_hit  = (state_q == IDLE) && rd_en && !wr_en && lb_valid_q
                     && (lb_tag_q == word_addr[16:1]);
    assign lb_half = word_addr[0] ? lb_data_q[63:32] : lb_data_q[31:0];
    assign read_data = lb_hit ? lb_half : rdata_q;
`else
    assign lb_hit    = 1'b0;
    assign read_data = rdata_q;
`endif

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        is_write_d = is_write_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        we_n_d     = we_n_q;
        dq_oe_d    = dq_oe_q;
`ifdef SRAM_LINE_BUF_EN
        lb_valid_d = lb_valid_q;
        lb_tag_d   = lb_tag_q;
        lb_data_d  = lb_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (wr_en || (rd_en && !lb_hit)) begin
                    state_d    = BUSY;
                    is_write_d = wr_en;
                    cnt_d      = '0;
                    addr_d     = word_addr;
                    wdata_d    = write_data;
                    // Bus controls are registered so WE_N and DQ enable cannot glitch.
                    we_n_d     = !wr_en;
                    dq_oe_d    = wr_en;
                end
`ifdef SRAM_LINE_BUF_EN
                else if (lb_hit) begin
                    // Keep the hit data visible after the request is withdrawn.
                    rdata_d = lb_half;
                end
`endif
            end
            BUSY: begin
                if (last_cycle) begin
                    state_d = DONE;
                    we_n_d  = 1'b1;
                    dq_oe_d = 1'b0;
                    if (!is_write_q) begin
                        rdata_d = dq_half;
`ifdef SRAM_LINE_BUF_EN
                        lb_valid_d = 1'b1;
                        lb_tag_d   = addr_q[16:1];
                        lb_data_d  = SRAM_DQ;
`endif
                    end
`ifdef SRAM_LINE_BUF_EN
                    else if (lb_tag_q == addr_q[16:1]) begin
                        // A store into the buffered line makes the copy stale.
                        lb_valid_d = 1'b0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs. An asynchronous reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: reset is asynchronous so WE_N rises and DQ is released without waiting for a clock.
        if (rst) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            we_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
`ifdef SRAM_LINE_BUF_EN
            lb_valid_q <= 1'b0;
            lb_tag_q   <= '0;
            lb_data_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            is_write_q <= is_write_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            we_n_q     <= we_n_d;
            dq_oe_q    <= dq_oe_d;
`ifdef SRAM_LINE_BUF_EN
            lb_valid_q <= lb_valid_d;
            lb_tag_q   <= lb_tag_d;
            lb_data_q  <= lb_data_d;
`endif
        end
    end

    // Stall while a new request is decoded or the SRAM is busy. The DONE cycle releases the pipeline.
    always_comb begin
        case (state_q)
            IDLE:    ready = !(wr_en || rd_en) || lb_hit;
            BUSY:    ready = 1'b0;
            default: ready = 1'b1;
        endcase
    end

    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_DQ   = dq_oe_q ? {32'h0, wdata_q} : {64{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed test of sram_controller against a simple
// behavioural SRAM. Expected values are hand-derived from the address map and
// from the access latency.
`timescale 1ns/1ps
module tb_sram_controller;

    localparam int BASE = 1024;
    localparam int WAIT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    wire  [31:0] read_data;
    wire         ready;
    wire  [16:0] sram_addr;
    wire         sram_we_n;
    wire  [63:0] sram_dq;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural SRAM. It drives the bus whenever the controller is not writing.
    logic [63:0] mem     [0:131071];
    logic [63:0] exp_mem [0:131071];
    assign sram_dq = sram_we_n ? mem[sram_addr] : {64{1'bz}};
    always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq;

    // Reference state kept by the bench.
    logic [31:0] exp_rd;
    logic [16:0] exp_addr;
    bit          lb_valid;
    logic [15:0] lb_tag;
    logic [63:0] lb_data;

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_DQ    (sram_dq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One access from request to the idle cycle that follows it. drop_after > 0
    // withdraws the request after that many stall cycles.
    task automatic do_access(input string tag, input bit wr, input bit rd,
                             input logic [31:0] addr, input logic [31:0] data,
                             input int drop_after);
        logic [16:0] word;
        bit          hit;
        bit          done;
        int          stall, we_cnt, dq_bad, exp_stall;
        word = 17'((addr - 32'(BASE)) >> 2);
        hit  = 1'b0;
`ifdef SRAM_LINE_BUF_EN
        hit = !wr && rd && lb_valid && (lb_tag == word[16:1]);
`endif
        exp_stall = hit ? 0 : WAIT + 1;
        if (wr) begin
            exp_mem[word] = {32'h0, data};
            if (lb_valid && lb_tag == word[16:1]) lb_valid = 1'b0;
        end else if (hit) begin
            exp_rd = word[0] ? lb_data[63:32] : lb_data[31:0];
        end else begin
            exp_rd   = word[0] ? exp_mem[word][63:32] : exp_mem[word][31:0];
            lb_valid = 1'b1;
            lb_tag   = word[16:1];
            lb_data  = exp_mem[word];
        end
        if (!hit) exp_addr = word;

        @(negedge clk);
        wr_en = wr; rd_en = rd; address = addr; write_data = data;
        stall = 0; we_cnt = 0; dq_bad = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (ready) begin
                done = 1'b1;
            end else begin
                stall++;
                if (!sram_we_n) begin
                    we_cnt++;
                    if (sram_dq !== {32'h0, data}) dq_bad++;
                end
                if (stall == drop_after) begin
                    wr_en = 1'b0; rd_en = 1'b0;
                end
                @(negedge clk);
            end
        end
        check({tag, " completes"}, done, 1'b1);
        check({tag, " stall cycles"}, stall, exp_stall);
        check({tag, " WE_N low cycles"}, we_cnt, wr ? WAIT : 0);
        if (wr) check({tag, " DQ write value"}, dq_bad, 0);
        check({tag, " read_data at ready"}, read_data, exp_rd);
        check({tag, " SRAM_ADDR"}, sram_addr, exp_addr);
        @(posedge clk);
        #1 wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        #1;
        check({tag, " idle ready"}, ready, 1'b1);
        check({tag, " read_data held"}, read_data, exp_rd);
        if (wr) check({tag, " SRAM contents"}, mem[word], {32'h0, data});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        for (int i = 0; i < 131072; i++) begin
            mem[i] = '0; exp_mem[i] = '0;
        end
        mem[4] = 64'h1234_5678_9ABC_DEF0; exp_mem[4] = 64'h1234_5678_9ABC_DEF0;
        mem[5] = 64'hA5A5_A5A5_5A5A_5A5A; exp_mem[5] = 64'hA5A5_A5A5_5A5A_5A5A;
        exp_rd = '0; exp_addr = '0; lb_valid = 1'b0; lb_tag = '0; lb_data = '0;

        #12;
        check("reset ready", ready, 1'b1);
        check("reset WE_N", sram_we_n, 1'b1);
        check("reset SRAM_ADDR", sram_addr, 17'd0);
        check("reset read_data", read_data, 32'h0);
        check("reset DQ released", sram_dq, exp_mem[0]);
        @(negedge clk) rst = 1'b0;

        do_access("wr 1024", 1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 0);
        do_access("rd 1024", 1'b0, 1'b1, 32'd1024, 32'h0, 0);
        do_access("wr 1028", 1'b1, 1'b0, 32'd1028, 32'h1111_1111, 0);
        do_access("wr 1032", 1'b1, 1'b0, 32'd1032, 32'h2222_2222, 0);
        do_access("rd 1028", 1'b0, 1'b1, 32'd1028, 32'h0, 0);
        do_access("rd 1032", 1'b0, 1'b1, 32'd1032, 32'h0, 0);
        do_access("rd 1044", 1'b0, 1'b1, 32'd1044, 32'h0, 0);
        do_access("wr+rd 1036", 1'b1, 1'b1, 32'd1036, 32'h3333_3333, 0);

        // Reset during the third BUSY cycle of a write.
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1048; write_data = 32'h4444_4444;
        repeat (3) @(negedge clk);
        #1 check("abort WE_N before reset", sram_we_n, 1'b0);
        rst = 1'b1; wr_en = 1'b0;
        #1;
        check("abort WE_N", sram_we_n, 1'b1);
        check("abort ready", ready, 1'b1);
        check("abort read_data", read_data, 32'h0);
        check("abort SRAM_ADDR", sram_addr, 17'd0);
        check("abort DQ released", sram_dq, exp_mem[0]);
        @(negedge clk) rst = 1'b0;
        exp_rd = '0; exp_addr = '0; lb_valid = 1'b0;

        do_access("rd 1040 dropped", 1'b0, 1'b1, 32'd1040, 32'h0, 2);
        do_access("rd 1024 again", 1'b0, 1'b1, 32'd1024, 32'h0, 0);
`ifdef SRAM_LINE_BUF_EN
        do_access("lb hit 1028", 1'b0, 1'b1, 32'd1028, 32'h0, 0);
        do_access("lb wr 1028", 1'b1, 1'b0, 32'd1028, 32'h5555_5555, 0);
        do_access("lb miss 1024", 1'b0, 1'b1, 32'd1024, 32'h0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
